// File: rtl/nonce_result_scanner_if.sv
// nonce_result_scanner_if: word-addressed memory port shared with the hash core.
// The master issues addresses and writes; the slave returns registered read data.
interface nonce_result_scanner_if;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        output mem_clk,
        output mem_we,
        output mem_addr,
        output mem_write_data,
        input  mem_read_data
    );

    modport slave (
        input  mem_clk,
        input  mem_we,
        input  mem_addr,
        input  mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/nonce_result_scanner.sv
// nonce_result_scanner: finds the smallest per-nonce h0 word and counts target hits.
// Define SCAN_WRITEBACK_EN to store best nonce/hash just past the scanned block.
module nonce_result_scanner #(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [15:0] best_nonce,
    output logic [31:0] best_hash,
    output logic [16:0] match_count,
    nonce_result_scanner_if.master mem
);
    localparam logic [15:0] LAST = 16'(NUM_NONCES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd5;
`ifdef SCAN_WRITEBACK_EN
    localparam logic [2:0] S_WB0   = 3'd3;
    localparam logic [2:0] S_WB1   = 3'd4;
    localparam logic [15:0] NUM    = 16'(NUM_NONCES);
`endif

    logic [2:0]  state;
    logic [31:0] tgt_q;
    logic [15:0] base_q;
    logic [15:0] rd_idx;
    logic [15:0] smp_idx;
    logic [1:0]  pipe;
    logic [15:0] addr_q;

    assign mem.mem_clk  = clk;
    assign mem.mem_addr = addr_q;
    assign found        = (match_count != 17'd0);

`ifdef SCAN_WRITEBACK_EN
    logic        we_q;
    logic [31:0] wd_q;
    assign mem.mem_we         = we_q;
    assign mem.mem_write_data = wd_q;
`else
    assign mem.mem_we         = 1'b0;
    assign mem.mem_write_data = 32'd0;
`endif

    // pipe[0]: an address went out last edge; pipe[1]: its data lands this edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            done        <= 1'b0;
            best_nonce  <= 16'd0;
            best_hash   <= 32'hFFFF_FFFF;
            match_count <= 17'd0;
            tgt_q       <= 32'd0;
            base_q      <= 16'd0;
            rd_idx      <= 16'd0;
            smp_idx     <= 16'd0;
            pipe        <= 2'b00;
            addr_q      <= 16'd0;
`ifdef SCAN_WRITEBACK_EN
            we_q        <= 1'b0;
            wd_q        <= 32'd0;
`endif
        end else begin
            pipe[1] <= pipe[0];
            pipe[0] <= 1'b0;
            if (pipe[1]) begin
                if (mem.mem_read_data < best_hash) begin
                    best_hash  <= mem.mem_read_data;
                    best_nonce <= smp_idx;
                end
                if (mem.mem_read_data < tgt_q)
                    match_count <= match_count + 17'd1;
                smp_idx <= smp_idx + 16'd1;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        tgt_q       <= target;
                        base_q      <= result_addr;
                        addr_q      <= result_addr;
                        rd_idx      <= 16'd1;
                        smp_idx     <= 16'd0;
                        best_hash   <= 32'hFFFF_FFFF;
                        best_nonce  <= 16'd0;
                        match_count <= 17'd0;
                        done        <= 1'b0;
                        pipe[0]     <= 1'b1;
                        state       <= S_READ;
                    end
                end
                S_READ: begin
                    addr_q  <= base_q + rd_idx;
                    rd_idx  <= rd_idx + 16'd1;
                    pipe[0] <= 1'b1;
                    if (rd_idx == LAST)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (pipe == 2'b00) begin
`ifdef SCAN_WRITEBACK_EN
                        we_q   <= 1'b1;
                        addr_q <= base_q + NUM;
                        wd_q   <= {16'd0, best_nonce};
                        state  <= S_WB0;
`else
                        done   <= 1'b1;
                        state  <= S_DONE;
`endif
                    end
                end
`ifdef SCAN_WRITEBACK_EN
                S_WB0: begin
                    addr_q <= base_q + NUM + 16'd1;
                    wd_q   <= best_hash;
                    state  <= S_WB1;
                end
                S_WB1: begin
                    we_q  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nonce_result_scanner.sv
// tb_nonce_result_scanner: randomized scans checked against a direct min/count model.
// Memory model returns data two edges after the address is registered.
module tb_nonce_result_scanner;
    localparam int N = 16;
`ifdef SCAN_WRITEBACK_EN
    localparam int LAT = N + 4;
`else
    localparam int LAT = N + 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] result_addr;
    logic [31:0] target;
    logic        done;
    logic        found;
    logic [15:0] best_nonce;
    logic [31:0] best_hash;
    logic [16:0] match_count;

    nonce_result_scanner_if bus();

    nonce_result_scanner #(.NUM_NONCES(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .result_addr (result_addr),
        .target      (target),
        .done        (done),
        .found       (found),
        .best_nonce  (best_nonce),
        .best_hash   (best_hash),
        .match_count (match_count),
        .mem         (bus)
    );

    logic [31:0] mem [0:65535];
    logic [31:0] rd_q;
    bit          we_seen;
    int          n_chk;
    int          n_pass;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_q <= mem[bus.mem_addr];
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_write_data;
    end
    assign bus.mem_read_data = rd_q;

    always @(negedge clk) if (bus.mem_we) we_seen = 1'b1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_found"}, 64'(found), 64'd0);
        check({tag, "_nonce"}, 64'(best_nonce), 64'd0);
        check({tag, "_hash"}, 64'(best_hash), 64'hFFFF_FFFF);
        check({tag, "_count"}, 64'(match_count), 64'd0);
        check({tag, "_addr"}, 64'(bus.mem_addr), 64'd0);
        check({tag, "_we"}, 64'(bus.mem_we), 64'd0);
        check({tag, "_wdata"}, 64'(bus.mem_write_data), 64'd0);
    endtask

    // Reference: plain min-scan and count over the words in memory
    task automatic model(input logic [15:0] base, input logic [31:0] tgt,
                         output logic [31:0] bh, output logic [15:0] bn,
                         output logic [16:0] mc);
        logic [31:0] w;
        bh = 32'hFFFF_FFFF;
        bn = 16'd0;
        mc = 17'd0;
        for (int i = 0; i < N; i++) begin
            w = mem[16'(base + 16'(i))];
            if (w < bh) begin
                bh = w;
                bn = 16'(i);
            end
            if (w < tgt) mc = mc + 17'd1;
        end
    endtask

    task automatic start_scan(input logic [15:0] base, input logic [31:0] tgt);
        @(negedge clk);
        result_addr = base;
        target      = tgt;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_scan(input string tag, input logic [15:0] base,
                            input logic [31:0] tgt);
        logic [31:0] eh;
        logic [15:0] en;
        logic [16:0] ec;
        int          lat;
        model(base, tgt, eh, en, ec);
        start_scan(base, tgt);
        check({tag, "_done_low"}, 64'(done), 64'd0);
        lat = -1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (cyc == 4) begin
                start       = 1'b1;
                target      = ~target;
                result_addr = 16'($urandom);
            end
            if (cyc == 5) start = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                lat = cyc;
                break;
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        check({tag, "_hash"}, 64'(best_hash), 64'(eh));
        check({tag, "_nonce"}, 64'(best_nonce), 64'(en));
        check({tag, "_count"}, 64'(match_count), 64'(ec));
        check({tag, "_found"}, 64'(found), 64'(ec != 17'd0));
`ifdef SCAN_WRITEBACK_EN
        check({tag, "_wb_nonce"}, 64'(mem[16'(base + 16'(N))]), 64'({16'd0, en}));
        check({tag, "_wb_hash"}, 64'(mem[16'(base + 16'(N + 1))]), 64'(eh));
`endif
    endtask

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        we_seen     = 1'b0;
        reset       = 1'b1;
        start       = 1'b0;
        result_addr = 16'd0;
        target      = 32'd0;
        for (int a = 0; a < 65536; a++) mem[a] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < N; i++) mem[i] = 32'(i) * 32'h1000_0000 + 32'd5;
        run_scan("ramp", 16'h0000, 32'h3000_0000);

        for (int i = 0; i < N; i++) mem[16'h0040 + i] = 32'hFFFF_FFFF;
        run_scan("allff", 16'h0040, 32'd0);

        for (int i = 0; i < N; i++) mem[16'h0080 + i] = 32'h20 - 32'(i);
        mem[16'h0089] = 32'd0;
        mem[16'h008C] = 32'd0;
        run_scan("ties", 16'h0080, 32'd1);

        for (int i = 0; i < N; i++) mem[16'(16'hFFF8 + 16'(i))] = $urandom;
        mem[16'h0003] = 32'd7;
        run_scan("wrap", 16'hFFF8, 32'h8000_0000);

        for (int i = 0; i < N; i++) mem[16'h0200 + i] = $urandom;
        start_scan(16'h0200, 32'hFFFF_FFFF);
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) mem[16'h0200 + i] = 32'h4000_0000 + $urandom_range(0, 255);
        run_scan("post_rst", 16'h0200, 32'h4000_0080);

        for (int t = 0; t < 8; t++) begin
            logic [15:0] b;
            logic [31:0] tg;
            b = 16'($urandom_range(16'h0400, 16'hF000));
            for (int i = 0; i < N; i++)
                mem[16'(b + 16'(i))] = ($urandom_range(0, 3) == 0) ?
                    32'($urandom_range(0, 1000)) : $urandom;
            case (t % 3)
                0: tg = 32'd0;
                1: tg = 32'hFFFF_FFFF;
                default: tg = $urandom;
            endcase
            run_scan($sformatf("rand%0d", t), b, tg);
        end

`ifdef SCAN_WRITEBACK_EN
        for (int i = 0; i < N; i++) mem[16'h0100 + i] = $urandom | 32'h0001_0000;
        mem[16'h0104] = 32'h0000_1234;
        run_scan("wb", 16'h0100, 32'h0000_2000);
`else
        check("no_write", 64'(we_seen), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
